// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider: operation encodings, the
// controller state enum, the default operand width and small op decoders.
// Optional build macro used by seq_divider: DIV_EARLY_OUT_EN.
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Signed ops treat operands as two's complement and divide magnitudes
    function automatic logic op_is_signed(logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Remainder ops return the remainder instead of the quotient
    function automatic logic op_is_rem(logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_sub_step.sv
// -----------------------------------------------------------------------------
// div_sub_step
// One restoring division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference when it is
// non-negative and report the resulting quotient bit.
// Ports:
//   rem_in   [WIDTH-1:0]  current partial remainder (always < divisor)
//   bit_in                next dividend bit, MSB first
//   divisor  [WIDTH-1:0]  divisor magnitude
//   rem_out  [WIDTH-1:0]  updated partial remainder
//   q_bit                 quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_sub_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The shifted remainder is below twice the divisor, so a WIDTH+1 bit
    // difference never overflows and its top bit is a reliable sign.
    // A clear sign bit means the subtraction fits and the quotient bit is 1.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle integer divider (DIV, DIVU, REM, REMU) using one restoring
// shift-subtract step per cycle on operand magnitudes, followed by a sign
// fix-up cycle. Divide-by-zero and signed overflow give fixed results.
// Build macro DIV_EARLY_OUT_EN: when defined, divide-by-zero and signed
// overflow requests skip the iterations and go straight to DONE.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      request handshake (ready only in IDLE)
//   op [1:0]                 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend, divisor        operands, captured on the accept edge
//   out_valid / out_ready    result handshake
//   result [WIDTH-1:0]       quotient or remainder
//   busy                     high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q;
    div_state_e       state_d;
    logic [CW-1:0]    iter_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_mag_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] result_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             div_zero_q;
    logic             overflow_q;
    logic             out_valid_q;

    logic             accept;
    logic             in_div_zero;
    logic             in_overflow;
    logic             in_neg_a;
    logic             in_neg_b;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] fix_result;

    // Fixed answers for the two corner cases, shared by the fix-up cycle and
    // the early-out path so both builds return identical values.
    function automatic logic [WIDTH-1:0] special_result(logic [1:0] o, logic zero,
                                                        logic [WIDTH-1:0] a);
        if (zero) begin
            return op_is_rem(o) ? a : '1;
        end
        return op_is_rem(o) ? '0 : a;
    endfunction

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

    // Decode the incoming request: corner cases, operand signs and the
    // magnitudes the iterations work on. Negating the most negative value
    // wraps to itself, which is the correct unsigned magnitude.
    always_comb begin
        in_div_zero = (divisor == '0);
        in_overflow = op_is_signed(op) && (dividend == MOST_NEG) && (divisor == '1);
        in_neg_a    = op_is_signed(op) && dividend[WIDTH-1];
        in_neg_b    = op_is_signed(op) && divisor[WIDTH-1];
        a_mag       = in_neg_a ? -dividend : dividend;
        b_mag       = in_neg_b ? -divisor : divisor;
    end

    div_sub_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (quo_q[WIDTH-1]),
        .divisor (divisor_mag_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    // Fix-up: corner cases override everything, otherwise the quotient is
    // negated when operand signs differed and the remainder follows the
    // dividend's sign.
    always_comb begin
        if (div_zero_q || overflow_q) begin
            fix_result = special_result(op_q, div_zero_q, dividend_q);
        end else if (op_is_rem(op_q)) begin
            fix_result = neg_rem_q ? -rem_q : rem_q;
        end else begin
            fix_result = neg_quo_q ? -quo_q : quo_q;
        end
    end

    // Controller state register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. CALC leaves after its WIDTH-th step (counter at
    // WIDTH-1 before the edge). DONE only leaves on the output handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef DIV_EARLY_OUT_EN
                    state_d = (in_div_zero || in_overflow) ? DONE : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                if (iter_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, then shift one quotient bit into
    // quo_q per CALC cycle while the dividend bits shift out of its top, and
    // latch the corrected answer in FIX. In the early-out build the corner
    // case answer is latched straight away on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_q        <= '0;
            op_q          <= '0;
            dividend_q    <= '0;
            divisor_mag_q <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            result_q      <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            div_zero_q    <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        iter_q        <= '0;
                        op_q          <= op;
                        dividend_q    <= dividend;
                        divisor_mag_q <= b_mag;
                        quo_q         <= a_mag;
                        rem_q         <= '0;
                        neg_quo_q     <= in_neg_a ^ in_neg_b;
                        neg_rem_q     <= in_neg_a;
                        div_zero_q    <= in_div_zero;
                        overflow_q    <= in_overflow;
`ifdef DIV_EARLY_OUT_EN
                        if (in_div_zero || in_overflow) begin
                            result_q <= special_result(op, in_div_zero, dividend);
                        end
`endif
                    end
                end
                CALC: begin
                    rem_q  <= step_rem;
                    quo_q  <= {quo_q[WIDTH-2:0], step_qbit};
                    iter_q <= iter_q + 1'b1;
                end
                FIX: begin
                    result_q <= fix_result;
                end
                default: begin
                end
            endcase
        end
    end

    // out_valid rises one cycle after DONE is entered and drops on the
    // handshake edge, the same edge that returns the controller to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_q == DONE) && !(out_valid_q && out_ready);
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (WIDTH=32): directed corner cases,
// backpressure, reset abort, then randomized requests compared against an
// arithmetic reference model. Honors DIV_EARLY_OUT_EN for expected latency.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 32;
    localparam int NORMAL_LAT = W + 2;
    localparam logic [1:0] T_DIV  = 2'b00;
    localparam logic [1:0] T_DIVU = 2'b01;
    localparam logic [1:0] T_REM  = 2'b10;
    localparam logic [1:0] T_REMU = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // Reference: plain integer arithmetic with the corner-case rules.
    function automatic logic [W-1:0] refModel(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
        longint sa;
        longint sb;
        logic   isRem;
        isRem = o[1];
        if (b == 0) return isRem ? a : '1;
        if (!o[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (sa == -64'sd2147483648 && sb == -64'sd1) return isRem ? '0 : a;
            return isRem ? W'(sa % sb) : W'(sa / sb);
        end
        return isRem ? (a % b) : (a / b);
    endfunction

    function automatic int expLatency(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
        logic special;
        special = (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
        return special ? 1 : NORMAL_LAT;
`else
        return (special === 1'bx) ? 0 : NORMAL_LAT;
`endif
    endfunction

    task automatic checkValue(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request mid-cycle; it is accepted at the next rising edge.
    // Afterwards the operand inputs are scrambled to prove they are ignored.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        checkValue("in_ready_pre_accept", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 2'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Called #1 after the accept edge: counts edges until out_valid, then
    // holds off the consumer for 'hold' cycles before the handshake.
    task automatic checkOutput(input string tag, input logic [W-1:0] exp, input int lat, input int hold);
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkValue({tag, "_latency"}, W'(n), W'(lat));
        checkValue({tag, "_result"}, result, exp);
        checkValue({tag, "_in_ready_done"}, W'(in_ready), W'(0));
        checkValue({tag, "_busy_done"}, W'(busy), W'(1));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkValue({tag, "_hold_valid"}, W'(out_valid), W'(1));
            checkValue({tag, "_hold_result"}, result, exp);
            checkValue({tag, "_hold_in_ready"}, W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkValue({tag, "_valid_after_hs"}, W'(out_valid), W'(0));
        checkValue({tag, "_in_ready_after_hs"}, W'(in_ready), W'(1));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sel;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset_in_ready", W'(in_ready), W'(1));
        checkValue("reset_out_valid", W'(out_valid), W'(0));
        checkValue("reset_busy", W'(busy), W'(0));
        checkValue("reset_result", result, '0);

        // First edge after reset release accepts
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(T_DIVU, 32'd100, 32'd7);
        checkOutput("divu_100_7", 32'd14, NORMAL_LAT, 0);
        applyStimulus(T_REMU, 32'd100, 32'd7);
        checkOutput("remu_100_7", 32'd2, NORMAL_LAT, 0);

        applyStimulus(T_DIV, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div_m7_2", 32'hFFFF_FFFD, NORMAL_LAT, 0);
        applyStimulus(T_REM, 32'hFFFF_FFF9, 32'd2);
        checkOutput("rem_m7_2", 32'hFFFF_FFFF, NORMAL_LAT, 0);

        applyStimulus(T_DIVU, 32'd5, 32'd0);
        checkOutput("divu_by0", 32'hFFFF_FFFF, expLatency(T_DIVU, 32'd5, 32'd0), 0);
        applyStimulus(T_DIV, 32'hFFFF_FFFB, 32'd0);
        checkOutput("div_by0", 32'hFFFF_FFFF, expLatency(T_DIV, 32'hFFFF_FFFB, 32'd0), 0);
        applyStimulus(T_REM, 32'h1234_5678, 32'd0);
        checkOutput("rem_by0", 32'h1234_5678, expLatency(T_REM, 32'h1234_5678, 32'd0), 0);

        applyStimulus(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div_ovf", 32'h8000_0000, expLatency(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 0);
        applyStimulus(T_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("rem_ovf", 32'h0, expLatency(T_REM, 32'h8000_0000, 32'hFFFF_FFFF), 0);

        // Backpressure, then a request the cycle right after the handshake
        applyStimulus(T_DIVU, 32'd1000, 32'd10);
        checkOutput("backpressure", 32'd100, NORMAL_LAT, 5);
        applyStimulus(T_DIVU, 32'd77, 32'd7);
        checkOutput("after_hs", 32'd11, NORMAL_LAT, 0);

        // Reset in the middle of CALC
        applyStimulus(T_DIVU, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkValue("abort_out_valid", W'(out_valid), W'(0));
        checkValue("abort_in_ready", W'(in_ready), W'(1));
        checkValue("abort_busy", W'(busy), W'(0));
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(T_DIVU, 32'd81, 32'd9);
        checkOutput("abort_follow", 32'd9, NORMAL_LAT, 0);

        // Randomized requests with corner values mixed in
        for (int k = 0; k < 60; k++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: rb = '0;
                1: begin
                    rb = '1;
                    if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000;
                end
                2, 3: rb = 32'($urandom_range(1, 20));
                4: begin
                    rb = $urandom;
                    ra = 32'($urandom_range(0, 500));
                end
                default: rb = $urandom;
            endcase
            applyStimulus(ro, ra, rb);
            checkOutput("rand", refModel(ro, ra, rb), expLatency(ro, ra, rb),
                        $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  divider can accept a request.
REQ-006 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 dividend  input  WIDTH  numerator.
REQ-008 divisor  input  WIDTH  denominator.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-014 Transitions:
- IDLE->CALC on in_valid && in_ready.
- CALC->FIX after exactly WIDTH iterations.
- FIX->DONE unconditionally.
- DONE->IDLE on out_valid && out_ready.
REQ-015 in_ready SHALL be 1 only in IDLE; op, dividend and divisor SHALL be registered on the accept edge and ignored afterwards.
REQ-016 Signed ops SHALL divide operand magnitudes, one restoring shift-subtract step per CALC cycle (MSB first).
REQ-017 FIX SHALL apply sign correction:
- Quotient is negated when the operand signs differ.
- Remainder takes the dividend's sign.
REQ-018 Normal latency: accept on edge 0 -> out_valid high after edge WIDTH+2.
REQ-019 out_valid and result SHALL stay stable in DONE until out_ready; a new request is not accepted in the same cycle as the output handshake.
REQ-020 Divide by zero SHALL give quotient all-ones (DIV and DIVU) and remainder = dividend (REM and REMU).
REQ-021 Signed overflow (DIV of most-negative value by -1) SHALL give quotient = dividend and remainder 0.
REQ-022 Arithmetic SHALL use WIDTH+1-bit partial remainders so no step overflows.

Reset
REQ-023 rst SHALL force IDLE asynchronously, from any state including mid-CALC, and abort any operation in progress.
REQ-024 Reset values: in_ready=1, out_valid=0, busy=0, result=0, iteration counter=0.
REQ-025 The first rising edge after rst deasserts SHALL be able to accept a request.

Configuration
REQ-026 With DIV_EARLY_OUT_EN defined:
- Divide-by-zero and signed-overflow requests SHALL go IDLE->DONE on the accept edge.
- Their out_valid SHALL be high after edge 1.
REQ-027 Without DIV_EARLY_OUT_EN:
- Divide-by-zero and signed-overflow requests SHALL be flagged at accept and run the full CALC/FIX sequence (latency WIDTH+2).
- FIX SHALL force the REQ-020/021 results.
REQ-028 Result values SHALL be identical with and without the macro; only latency differs.

Structure
REQ-029 A shared package div_pkg SHALL hold:
- the op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU);
- the FSM state enum;
- the default WIDTH constant.
REQ-030 One combinational sub-module, div_sub_step, SHALL implement a single restoring step: shift, subtract, select, and the quotient bit.
REQ-031 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-032 DIVU 100/7 -> result 14 after edge 34; REMU 100/7 -> 2.
REQ-033 DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-034 Divide by zero:
- DIVU 5/0 -> 0xFFFFFFFF; DIV 0xFFFFFFFB/0 -> 0xFFFFFFFF; REM 0x12345678/0 -> 0x12345678.
- out_valid after edge 1 with DIV_EARLY_OUT_EN, after edge 34 without.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-036 Backpressure: out_ready held 0 for 5 cycles in DONE -> result stable, in_ready 0; next request accepted the cycle after the handshake.
REQ-037 Reset abort: rst pulsed at CALC iteration 10 -> out_valid 0 and in_ready 1 immediately; following DIVU 81/9 -> 9.
